// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared types and constants for the two-port ALU arbiter.
// The FSM state encoding, the ALU opcode values and the default operand
// width live here so the top, the pick sub-module and the bench agree.
package alu_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Opcodes as seen by the shared ALU; the arbiter forwards them untouched.
  // 2'b10 also selects xor in the ALU.
  localparam logic [1:0] OP_XOR = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_arbiter_pick.sv
// alu_arbiter_pick: chooses which requester owns the next ALU operation.
// Build option ALU_ARBITER_RR_EN: when defined, a tie goes to the requester
// that did not win last time; when undefined, requester 0 always wins a tie
// and no last-grant history is needed.
module alu_arbiter_pick
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] valid,
`ifdef ALU_ARBITER_RR_EN
  input  logic       last_grant,
`endif
  output logic [1:0] grant
);

  // One-hot grant; all zero when nobody is requesting.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
`ifdef ALU_ARBITER_RR_EN
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
`else
      2'b11:   grant = 2'b01;
`endif
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// A request is accepted in IDLE, its operands are registered onto alu_a /
// alu_b / alu_op for one EXEC cycle, the ALU result is captured into
// rsp_data, and RESP holds it until the owning requester takes it.
// Build option ALU_ARBITER_RR_EN selects round-robin tie breaking (default
// build: fixed priority to requester 0).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH:0]   rsp_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH:0]   alu_rout,
  output logic             busy,
  output logic             grant_id
);

  state_t     state_r;
  state_t     next_state_s;
  logic [1:0] grant_s;
  logic       accept_s;
  logic       rsp_hs_s;

`ifdef ALU_ARBITER_RR_EN
  logic       last_grant_r;
`endif

  alu_arbiter_pick u_pick (
    .valid      ({req1_valid, req0_valid}),
`ifdef ALU_ARBITER_RR_EN
    .last_grant (last_grant_r),
`endif
    .grant      (grant_s)
  );

  // Request ready is only offered in IDLE, and only to the picked requester.
  assign req0_ready = accept_s & grant_s[0];
  assign req1_ready = accept_s & grant_s[1];

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; only the owning channel's ready can close RESP.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    rsp_hs_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_s != 2'b00) begin
          accept_s     = 1'b1;
          next_state_s = EXEC;
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC: begin
        next_state_s = RESP;
      end
      RESP: begin
        rsp_hs_s = grant_id ? rsp1_ready : rsp0_ready;
        if (rsp_hs_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Operand capture on accept, result capture at the end of EXEC, response
  // valids and busy tracked as registers so every non-ready output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= {WIDTH{1'b0}};
      alu_b      <= {WIDTH{1'b0}};
      alu_op     <= 2'b00;
      grant_id   <= 1'b0;
      rsp_data   <= {(WIDTH+1){1'b0}};
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (accept_s) begin
        alu_a    <= grant_s[1] ? req1_a  : req0_a;
        alu_b    <= grant_s[1] ? req1_b  : req0_b;
        alu_op   <= grant_s[1] ? req1_op : req0_op;
        grant_id <= grant_s[1];
      end
      if (state_r == EXEC) begin
        rsp_data   <= alu_rout;
        rsp0_valid <= ~grant_id;
        rsp1_valid <= grant_id;
      end else if (rsp_hs_s) begin
        rsp0_valid <= 1'b0;
        rsp1_valid <= 1'b0;
      end
      busy <= (next_state_s != IDLE);
    end
  end

`ifdef ALU_ARBITER_RR_EN
  // Round-robin history; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      last_grant_r <= grant_s[1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed, table-driven bench for alu_arbiter with a
// behavioural ALU model standing in for the parent's ALU instance.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [16:0] rsp_data;
  logic [15:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [16:0] alu_rout;
  logic        busy, grant_id;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs [6];

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_rout(alu_rout),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Reference ALU: add, sub (A-B, 17-bit wrap), xor for 00/10.
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_rout = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:  alu_rout = {1'b0, alu_a} - {1'b0, alu_b};
      default: alu_rout = {1'b0, alu_a ^ alu_b};
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a request (called just after a negedge) and hold it until the
  // accept edge has passed; returns at the negedge inside EXEC.
  task automatic issue(input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] op, output bit ok);
    ok = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    for (int cyc = 0; cyc < 20 && !ok; cyc++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      check("req_ready_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     {31'd0, busy},       32'd0);
    check({tag, "_rsp0_vld"}, {31'd0, rsp0_valid}, 32'd0);
    check({tag, "_rsp1_vld"}, {31'd0, rsp1_valid}, 32'd0);
    check({tag, "_req0_rdy"}, {31'd0, req0_ready}, 32'd0);
    check({tag, "_req1_rdy"}, {31'd0, req1_ready}, 32'd0);
    check({tag, "_rsp_data"}, {15'd0, rsp_data},   32'd0);
    check({tag, "_alu_a"},    {16'd0, alu_a},      32'd0);
    check({tag, "_alu_b"},    {16'd0, alu_b},      32'd0);
    check({tag, "_alu_op"},   {30'd0, alu_op},     32'd0);
    check({tag, "_grant_id"}, {31'd0, grant_id},   32'd0);
  endtask

  initial begin
    bit   ok;
    logic exp_pick [4];
    logic pick;

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 16'h0000; req0_b = 16'h0000; req0_op = 2'b00;
    req1_a = 16'h0000; req1_b = 16'h0000; req1_op = 2'b00;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    vecs[0] = '{1'b0, 16'h0003, 16'h0004, 2'b01, 17'h00007};
    vecs[1] = '{1'b1, 16'h0010, 16'h0001, 2'b11, 17'h0000F};
    vecs[2] = '{1'b1, 16'h00FF, 16'h0F0F, 2'b00, 17'h00FF0};
    vecs[3] = '{1'b0, 16'hAAAA, 16'h5555, 2'b10, 17'h0FFFF};
    vecs[4] = '{1'b0, 16'h0000, 16'h0001, 2'b11, 17'h1FFFF};
    vecs[5] = '{1'b1, 16'hFFFF, 16'h0001, 2'b01, 17'h10000};

    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Idle stability.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || alu_op !== 2'b00 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
          rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0)
        check("idle_quiet", {26'd0, busy, alu_op, req0_ready, req1_ready, rsp0_valid | rsp1_valid}, 32'd0);
      else
        check("idle_quiet", 32'd0, 32'd0 + {31'd0, busy});
    end

    // Single-requester operations from the table.
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, ok);
      if (ok) begin
        check("exec_busy",     {31'd0, busy}, 32'd1);
        check("exec_no_rsp",   {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        @(negedge clk);
        check("rsp_valid_own", {31'd0, vecs[i].id ? rsp1_valid : rsp0_valid}, 32'd1);
        check("rsp_valid_oth", {31'd0, vecs[i].id ? rsp0_valid : rsp1_valid}, 32'd0);
        check("rsp_data",      {15'd0, rsp_data}, {15'd0, vecs[i].exp});
        check("grant_id",      {31'd0, grant_id}, {31'd0, vecs[i].id});
        check("alu_op_pass",   {30'd0, alu_op},   {30'd0, vecs[i].op});
        if (vecs[i].id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        check("rsp_done_busy", {31'd0, busy}, 32'd0);
        check("rsp_done_vld",  {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      end
    end

    // Contention after reset: both requesters held valid for 4 operations.
`ifdef ALU_ARBITER_RR_EN
    exp_pick = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_pick = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_a = 16'h0001; req0_b = 16'h0002; req0_op = OP_ADD;
    req1_a = 16'h0005; req1_b = 16'h0003; req1_op = OP_SUB;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int op_n = 0; op_n < 4; op_n++) begin
      ok = 1'b0;
      for (int cyc = 0; cyc < 10 && !ok; cyc++) begin
        #1;
        if (req0_ready === 1'b1 || req1_ready === 1'b1) ok = 1'b1;
        else @(negedge clk);
      end
      if (!ok) begin
        check("contend_timeout", 32'd0, 32'd1);
      end else begin
        check("contend_one_rdy", {31'd0, req0_ready & req1_ready}, 32'd0);
        pick = req1_ready;
        check("contend_grant", {31'd0, pick}, {31'd0, exp_pick[op_n]});
        @(negedge clk);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    check("contend_end_idle", {31'd0, busy}, 32'd0);

    // Response backpressure on rsp0 while req1 waits; rsp1_ready must be ignored.
    issue(1'b0, 16'h1234, 16'h0101, OP_XOR, ok);
    @(negedge clk);
    check("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    req1_a = 16'hFFFF; req1_b = 16'h0001; req1_op = OP_ADD;
    req1_valid = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_data_hold", {15'd0, rsp_data}, 32'h00001335);
      check("bp_req1_wait", {31'd0, req1_ready}, 32'd0);
      check("bp_rsp0_hold", {31'd0, rsp0_valid}, 32'd1);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    check("bp_req1_next", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    check("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    check("bp_rsp1_data",  {15'd0, rsp_data}, 32'h00010000);
    check("bp_grant_id",   {31'd0, grant_id}, 32'd1);
    @(negedge clk);
    rsp1_ready = 1'b0;
    check("bp_done", {31'd0, busy}, 32'd0);

    // Reset during EXEC aborts the operation.
    issue(1'b1, 16'h00F0, 16'h000F, OP_ADD, ok);
    check("rexec_in_exec", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rexec");
    @(negedge clk);
    rst = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rexec_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end

    // First tie after reset goes to requester 0.
    req0_a = 16'h0100; req0_b = 16'h0001; req0_op = OP_ADD;
    req1_a = 16'h0002; req1_b = 16'h0002; req1_op = OP_XOR;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("tie_req0_rdy", {31'd0, req0_ready}, 32'd1);
    check("tie_req1_rdy", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("tie_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("tie_data", {15'd0, rsp_data}, 32'h00000101);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    check("tie_done", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
